ball_tracker: RTL

BALL_TRACKER -- requirements
Module: ball_tracker

---
 rtl/ball_pkg.sv | 41 ++++
 rtl/seq_divider.sv | 51 +++++
 rtl/ball_tracker.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/ball_pkg.sv
// Shared definitions for the ball tracker: FSM states, datapath widths,
// default frame geometry and the restoring-division step.
package ball_pkg;

    localparam int CNT_W            = 13;
    localparam int SUM_W            = 32;
    localparam int COUNT_W          = 20;
    localparam int H_ACTIVE_DEFAULT = 640;
    localparam int V_ACTIVE_DEFAULT = 480;

    typedef enum logic [1:0] {
        ACCUM,
        DIV_X,
        DIV_Y,
        PUBLISH
    } state_t;

    // Partial remainder and the dividend/quotient shift register of the divider.
    typedef struct packed {
        logic [COUNT_W-1:0] rem;
        logic [SUM_W-1:0]   quo;
    } div_work_t;

    // One restoring-division iteration: shift the next dividend bit into the
    // remainder, subtract the divisor when it fits, shift in the quotient bit.
    function automatic div_work_t div_step(input div_work_t cur,
                                           input logic [COUNT_W-1:0] divisor);
        logic [COUNT_W:0] trial;
        div_work_t        nxt;
        trial = {cur.rem, cur.quo[SUM_W-1]};
        if (trial >= {1'b0, divisor}) begin
            nxt.rem = COUNT_W'(trial - {1'b0, divisor});
            nxt.quo = {cur.quo[SUM_W-2:0], 1'b1};
        end else begin
            nxt.rem = trial[COUNT_W-1:0];
            nxt.quo = {cur.quo[SUM_W-2:0], 1'b0};
        end
        return nxt;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Sequential 32/20-bit restoring divider with a start/done handshake.
// The first iteration happens on the start edge; done pulses for one cycle
// once all 32 iterations have completed, with the truncated quotient valid.
module seq_divider
    import ball_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [SUM_W-1:0]   dividend,
    input  logic [COUNT_W-1:0] divisor,
    output logic [SUM_W-1:0]   quotient,
    output logic               done
);

    div_work_t          work;
    logic [COUNT_W-1:0] divisor_q;
    logic [4:0]         iter_left;
    logic               busy;

    // Load and first iteration on start, then one iteration per cycle until done.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work      <= '0;
            divisor_q <= '0;
            iter_left <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                work      <= div_step(div_work_t'{rem: '0, quo: dividend}, divisor);
                divisor_q <= divisor;
                iter_left <= 5'(SUM_W - 1);
                busy      <= 1'b1;
            end else if (busy) begin
                work      <= div_step(work, divisor_q);
                iter_left <= iter_left - 5'd1;
                if (iter_left == 5'd1) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient = work.quo;

endmodule

// File: rtl/ball_tracker.sv
// Ball centroid tracker: accumulates the coordinates of ball-coloured pixels
// over a frame, divides by the hit count once the last active pixel has been
// seen, and publishes the centroid with a one-cycle strobe.
// Optional macro BALL_TRACKER_BBOX_EN adds BALL_W/BALL_H bounding-box outputs.
module ball_tracker
    import ball_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
    parameter int V_ACTIVE = V_ACTIVE_DEFAULT,
    parameter int MIN_HITS = 16
)(
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             ENABLE,
    input  logic             HIT,
    input  logic [CNT_W-1:0] VGA_H_CNT,
    input  logic [CNT_W-1:0] VGA_V_CNT,
    output logic [CNT_W-1:0] BALL_X,
    output logic [CNT_W-1:0] BALL_Y,
    output logic             BALL_VALID,
    output logic             POS_STROBE,
`ifdef BALL_TRACKER_BBOX_EN
    output logic [CNT_W-1:0] BALL_W,
    output logic [CNT_W-1:0] BALL_H,
`endif
    output logic             ERR_OVERRUN
);

    state_t             state;
    logic [SUM_W-1:0]   sum_x, sum_y, sum_x_next, sum_y_next;
    logic [COUNT_W-1:0] count, count_next;
    logic [CNT_W-1:0]   cent_x;
    logic               launch;
    logic               div_done;
    logic [SUM_W-1:0]   div_quo;
    logic [SUM_W-1:0]   div_dividend;
    logic               unused_quo_hi;

    logic active, hit_px, sof, last_px, is_ball, acc_clear, acc_load;

    assign active    = (VGA_H_CNT < CNT_W'(H_ACTIVE)) && (VGA_V_CNT < CNT_W'(V_ACTIVE));
    assign hit_px    = active && HIT;
    assign sof       = (VGA_H_CNT == '0) && (VGA_V_CNT == '0);
    assign last_px   = (VGA_H_CNT == CNT_W'(H_ACTIVE - 1)) && (VGA_V_CNT == CNT_W'(V_ACTIVE - 1));
    assign acc_clear = !ENABLE || (state == PUBLISH);
    assign acc_load  = ENABLE && (state == ACCUM);

    // Next accumulator values for an ACCUM cycle, with frame resync on (0,0).
    // NOTE: combinational blocks assign every output a default first so no
    // path leaves a value unassigned and infers a latch.
    always_comb begin
        sum_x_next = sof ? '0 : sum_x;
        sum_y_next = sof ? '0 : sum_y;
        count_next = sof ? '0 : count;
        if (hit_px) begin
            sum_x_next = sum_x_next + SUM_W'(VGA_H_CNT);
            sum_y_next = sum_y_next + SUM_W'(VGA_V_CNT);
            count_next = count_next + COUNT_W'(1);
        end
    end

    // A zero count is never divided, whatever MIN_HITS is set to.
    assign is_ball = (count_next >= COUNT_W'(MIN_HITS)) && (count_next != '0);

    // Frame accumulators: cleared on publish or disable, loaded while accumulating.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sum_x <= '0;
            sum_y <= '0;
            count <= '0;
        end else if (acc_clear) begin
            sum_x <= '0;
            sum_y <= '0;
            count <= '0;
        end else if (acc_load) begin
            sum_x <= sum_x_next;
            sum_y <= sum_y_next;
            count <= count_next;
        end
    end

`ifdef BALL_TRACKER_BBOX_EN
    logic [CNT_W-1:0] min_x, max_x, min_y, max_y;
    logic [CNT_W-1:0] min_x_next, max_x_next, min_y_next, max_y_next;

    // Bounding-box extremes for an ACCUM cycle; an empty box is min=all-ones, max=0.
    always_comb begin
        min_x_next = sof ? '1 : min_x;
        max_x_next = sof ? '0 : max_x;
        min_y_next = sof ? '1 : min_y;
        max_y_next = sof ? '0 : max_y;
        if (hit_px) begin
            if (VGA_H_CNT < min_x_next) min_x_next = VGA_H_CNT;
            if (VGA_H_CNT > max_x_next) max_x_next = VGA_H_CNT;
            if (VGA_V_CNT < min_y_next) min_y_next = VGA_V_CNT;
            if (VGA_V_CNT > max_y_next) max_y_next = VGA_V_CNT;
        end
    end

    // Bounding-box registers follow the same clear/load rules as the sums.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            min_x <= '1;
            max_x <= '0;
            min_y <= '1;
            max_y <= '0;
        end else if (acc_clear) begin
            min_x <= '1;
            max_x <= '0;
            min_y <= '1;
            max_y <= '0;
        end else if (acc_load) begin
            min_x <= min_x_next;
            max_x <= max_x_next;
            min_y <= min_y_next;
            max_y <= max_y_next;
        end
    end
`endif

    // One divider serves both axes; the FSM state selects the dividend.
    assign div_dividend = (state == DIV_Y) ? sum_y : sum_x;

    seq_divider u_div (
        .clk      (CLK),
        .rst_n    (RST_N),
        .start    (launch),
        .dividend (div_dividend),
        .divisor  (count),
        .quotient (div_quo),
        .done     (div_done)
    );

    // The centroid never exceeds the active area, so the upper quotient bits are always zero.
    assign unused_quo_hi = ^div_quo[SUM_W-1:CNT_W];

    // Control FSM with registered outputs; the strobe and published values are
    // loaded on the edge that enters PUBLISH so they are visible during it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= ACCUM;
            launch      <= 1'b0;
            cent_x      <= '0;
            BALL_X      <= '0;
            BALL_Y      <= '0;
            BALL_VALID  <= 1'b0;
            POS_STROBE  <= 1'b0;
            ERR_OVERRUN <= 1'b0;
`ifdef BALL_TRACKER_BBOX_EN
            BALL_W      <= '0;
            BALL_H      <= '0;
`endif
        end else begin
            POS_STROBE <= 1'b0;
            launch     <= 1'b0;
            if (hit_px && (state != ACCUM)) begin
                ERR_OVERRUN <= 1'b1;
            end
            if (!ENABLE) begin
                state      <= ACCUM;
                BALL_VALID <= 1'b0;
            end else begin
                case (state)
                    ACCUM: begin
                        if (last_px) begin
                            if (is_ball) begin
                                state  <= DIV_X;
                                launch <= 1'b1;
                            end else begin
                                state      <= PUBLISH;
                                POS_STROBE <= 1'b1;
                                BALL_VALID <= 1'b0;
`ifdef BALL_TRACKER_BBOX_EN
                                BALL_W     <= '0;
                                BALL_H     <= '0;
`endif
                            end
                        end
                    end
                    DIV_X: begin
                        if (div_done) begin
                            cent_x <= div_quo[CNT_W-1:0];
                            state  <= DIV_Y;
                            launch <= 1'b1;
                        end
                    end
                    DIV_Y: begin
                        if (div_done) begin
                            BALL_X     <= cent_x;
                            BALL_Y     <= div_quo[CNT_W-1:0];
                            BALL_VALID <= 1'b1;
                            POS_STROBE <= 1'b1;
`ifdef BALL_TRACKER_BBOX_EN
                            BALL_W     <= max_x - min_x + CNT_W'(1);
                            BALL_H     <= max_y - min_y + CNT_W'(1);
`endif
                            state      <= PUBLISH;
                        end
                    end
                    PUBLISH: begin
                        state <= ACCUM;
                    end
                    default: begin
                        state <= ACCUM;
                    end
                endcase
            end
        end
    end

endmodule
